// File: rtl/jtcontra_colmix.sv
// Colour mixer for the two 007121 engines: layer priority,
// xBGR555 palette lookup and blanking-aligned RGB output.
module jtcontra_colmix #(
    parameter int BLANK_DLY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic [6:0] pxl_a,
    input  logic [6:0] pxl_b,
    input  logic [1:0] gfx_en,
    input  logic       cpu_cen,
    input  logic       cpu_rnw,
    input  logic       pal_cs,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_dout,
    output logic [7:0] pal_dout,
    output logic [4:0] red,
    output logic [4:0] green,
    output logic [4:0] blue,
    output logic       LHBL_dly,
    output logic       LVBL_dly
);

    logic [7:0] pal_lo [0:127];
    logic [7:0] pal_hi [0:127];

    logic [6:0]           sel;
    logic [6:0]           idx;
    logic                 look;
    logic [7:0]           lo_q;
    logic [6:0]           hi_q;
    logic [BLANK_DLY-1:0] hsh;
    logic [BLANK_DLY-1:0] vsh;
    logic                 a_opaque;
    logic                 b_opaque;
    logic                 cpu_we;
    logic                 show;

    assign cpu_we   = cpu_cen & pal_cs & ~cpu_rnw;
    assign LHBL_dly = hsh[BLANK_DLY-1];
    assign LVBL_dly = vsh[BLANK_DLY-1];
    // flags that move into the output stage on the next pxl_cen
    assign show     = hsh[BLANK_DLY-2] & vsh[BLANK_DLY-2];

    // front engine wins when opaque; backdrop entry 0 otherwise
    always_comb begin
        a_opaque = gfx_en[0] & (pxl_a[3:0] != 4'd0);
        b_opaque = gfx_en[1] & (pxl_b[3:0] != 4'd0);
        sel      = 7'd0;
        if (a_opaque)
            sel = pxl_a;
        else if (b_opaque)
            sel = pxl_b;
    end

    // CPU port writes one byte into the bank picked by addr[0]
    always_ff @(posedge clk) begin
        if (cpu_we) begin
            if (cpu_addr[0])
                pal_hi[cpu_addr[7:1]] <= cpu_dout;
            else
                pal_lo[cpu_addr[7:1]] <= cpu_dout;
        end
    end

    // display lookup happens once, on the clk right after pxl_cen
    always_ff @(posedge clk) begin
        if (look) begin
            lo_q <= pal_lo[idx];
            hi_q <= pal_hi[idx][6:0];
        end
    end

    // CPU read data, held while the palette is not selected
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pal_dout <= 8'd0;
        else if (pal_cs)
            pal_dout <= cpu_addr[0] ? pal_hi[cpu_addr[7:1]]
                                    : pal_lo[cpu_addr[7:1]];
    end

    // select stage and blanking delay line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= 7'd0;
            look <= 1'b0;
            hsh  <= '0;
            vsh  <= '0;
        end else begin
            look <= pxl_cen;
            if (pxl_cen) begin
                idx <= sel;
                hsh <= {hsh[BLANK_DLY-2:0], LHBL};
                vsh <= {vsh[BLANK_DLY-2:0], LVBL};
            end
        end
    end

    // output stage: decode xBGR555 or force black while blanking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red   <= 5'd0;
            green <= 5'd0;
            blue  <= 5'd0;
        end else if (pxl_cen) begin
            if (show) begin
                red   <= lo_q[4:0];
                green <= {hi_q[1:0], lo_q[7:5]};
                blue  <= hi_q[6:2];
            end else begin
                red   <= 5'd0;
                green <= 5'd0;
                blue  <= 5'd0;
            end
        end
    end

endmodule

// File: doc/jtcontra_colmix.md
Name: jtcontra_colmix

Overview:
- Downstream colour stage for the two 007121 graphics engines (jtcontra_gfx).
- Takes each engine's 7-bit pxl_out and picks one by layer priority.
- Looks the chosen index up in CPU-written palette RAM (128 entries, xBGR555) and drives 5:5:5 RGB with delayed blanking to the video output.
- All logic on one clock, advanced by pxl_cen; CPU access is gated by cpu_cen.

Parameters:
BLANK_DLY, 2, number of pxl_cen pulses by which LHBL/LVBL are delayed; must equal pixel pipeline latency.

Ports:
clk  in  1  system clock (only clock)
rst  in  1  asynchronous reset, active-high
pxl_cen  in  1  pixel clock enable
LHBL  in  1  horizontal blank, active low, aligned with pxl_a/pxl_b
LVBL  in  1  vertical blank, active low, aligned with pxl_a/pxl_b
pxl_a  in  7  engine A (front) pixel: [6:5] bank, [4] tile/obj, [3:0] colour
pxl_b  in  7  engine B (back) pixel, same format
gfx_en  in  2  layer enables: [0] engine A, [1] engine B
cpu_cen  in  1  CPU clock enable
cpu_rnw  in  1  1 = read, 0 = write
pal_cs  in  1  palette RAM select
cpu_addr  in  8  byte address; [7:1] entry, [0] 0 = low byte, 1 = high byte
cpu_dout  in  8  CPU write data
pal_dout  out  8  CPU read data
red  out  5  red output
green  out  5  green output
blue  out  5  blue output
LHBL_dly  out  1  LHBL delayed BLANK_DLY pxl_cen
LVBL_dly  out  1  LVBL delayed BLANK_DLY pxl_cen

Behaviour:
- Reset (asynchronous, active-high):
  - red, green, blue, LHBL_dly, LVBL_dly and pal_dout go to 0.
  - All pipeline registers clear.
  - Palette RAM contents are not cleared.
- Palette RAM: two 128x8 banks, low and high, each with a CPU port and a display port; reads are registered (1 clk).
- Entry format:
  - low byte = G[2:0],R[4:0]; high byte = x,B[4:0],G[4:3].
  - R = lo[4:0]; G = {hi[1:0],lo[7:5]}; B = hi[6:2]; hi[7] is ignored.
- CPU write: when cpu_cen & pal_cs & ~cpu_rnw, write cpu_dout to bank cpu_addr[0] at entry cpu_addr[7:1]. Exactly one byte per write.
- CPU read: pal_dout = registered data of the addressed bank, valid 1 clk after the address. pal_dout holds when pal_cs is low.
- Pipeline, advancing only on pxl_cen:
  - S1 select:
    - a_opaque = gfx_en[0] & (pxl_a[3:0]!=0); b_opaque = gfx_en[1] & (pxl_b[3:0]!=0).
    - idx = a_opaque ? pxl_a : b_opaque ? pxl_b : 7'd0.
    - idx is registered along with LHBL and LVBL.
  - S2 lookup: both banks are read at idx; blank flags advance one stage.
  - S3 output: if the stage-2 blank flags show blanking (either flag low), RGB = 0; otherwise decode the entry. LHBL_dly/LVBL_dly = stage-2 flags.
- Latency: an input pixel reaches RGB on the 2nd pxl_cen after sampling, which is why BLANK_DLY defaults to 2. The RAM read completes between pxl_cen pulses, so pxl_cen must be at most every 2nd clk.
- Collision: a CPU write and a display read of the same entry in the same clk → display gets the old value; the new value appears from the next lookup.
- Both layers transparent or disabled → entry 0 is shown (backdrop).
- gfx_en change: takes effect at the next S1 sample; no glitch on the pixel in flight.
- pxl_cen held low: all outputs hold. CPU access still works.
- Reset mid-line: outputs go to 0 at once. The first valid colour appears 2 pxl_cen after reset is released.

Test Plan:
- Reset release with pxl_cen every 4th clk → RGB=0 and LHBL_dly=LVBL_dly=0 until 2 pxl_cen have passed; then the delayed blank flags track the inputs exactly.
- Write entry 0x15: lo=0xE3 (addr 0x2A), hi=0x7D (addr 0x2B); drive pxl_a=0x15, LHBL=LVBL=1 → 2 pxl_cen later red=0x03, green=0x0F, blue=0x1F.
- pxl_a=0x20 (transparent) with pxl_b=0x47 → entry 0x47 shown; then gfx_en=2'b10 with pxl_a=0x15 → entry of pxl_b shown; gfx_en=0 → entry 0.
- CPU writes 0xAA to 0x10, then reads 0x10 → pal_dout=0xAA one clk after the read strobe; 0x11 is unaffected.
- LHBL=0 with opaque pixel 0x15 → RGB=0 exactly on the pxl_cen where LHBL_dly falls; the colour returns on the pxl_cen where LHBL_dly rises.
- Write entry 0x15 on the same clk the display reads it → that pixel shows the old colour and the next pixel shows the new one; then assert rst mid-line → outputs 0 immediately.
